// File: rtl/vga_dither_out.sv
// rtl/vga_dither_out.sv - 2x2 ordered-dither output stage for the VGA PMOD with matched sync delay
module vga_dither_out #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2,
    parameter bit TEMPORAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*IN_BITS-1:0]    rgb_in,
    input  logic                    active_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    pixel_en,
    input  logic                    new_line,
    input  logic                    new_frame,
    input  logic                    dither_en,
    output logic [3*OUT_BITS-1:0]   rgb_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    active_out
);

    // Raster phase counters: column parity, line parity, frame rotation
    logic       xph_q, xph_d;
    logic       yph_q, yph_d;
    logic [1:0] frame_q, frame_d;

    // Threshold for the pixel currently on the inputs
    logic [1:0] t0;
    logic [1:0] thr;

    // Stage 1: input capture, aligned with the threshold of its pixel
    logic [3*IN_BITS-1:0] rgb_s1_q, rgb_s1_d;
    logic                 active_s1_q, active_s1_d;
    logic                 hsync_s1_q, hsync_s1_d;
    logic                 vsync_s1_q, vsync_s1_d;
    logic [1:0]           thr_s1_q, thr_s1_d;
    logic                 dither_en_s1_q, dither_en_s1_d;

    // Stage 2: quantised colour and sync, driven straight to the pins
    logic [3*OUT_BITS-1:0] rgb_out_q, rgb_out_d;
    logic                  hsync_out_q, hsync_out_d;
    logic                  vsync_out_q, vsync_out_d;
    logic                  active_out_q, active_out_d;

    // Reduce one channel: keep the top OUT_BITS, bump by one when the next two
    // fraction bits exceed the threshold, and clamp at full scale instead of wrapping.
    function automatic logic [OUT_BITS-1:0] quantise(
        input logic [IN_BITS-1:0] ch,
        input logic [1:0]         t,
        input logic               den
    );
        logic [OUT_BITS-1:0] hi;
        logic [1:0]          frac;
        logic                bump;
        logic [OUT_BITS:0]   sum;
        hi   = ch[IN_BITS-1 -: OUT_BITS];
        frac = ch[IN_BITS-OUT_BITS-1 -: 2];
        bump = den && (frac > t);
        sum  = {1'b0, hi} + {{OUT_BITS{1'b0}}, bump};
        if (sum[OUT_BITS]) begin
            return {OUT_BITS{1'b1}};
        end
        return sum[OUT_BITS-1:0];
    endfunction

    // Bayer lookup from the current phase, rotated by the frame counter
    always_comb begin
        t0 = 2'd0;
        case ({yph_q, xph_q})
            2'b00:   t0 = 2'd0;
            2'b01:   t0 = 2'd2;
            2'b10:   t0 = 2'd3;
            default: t0 = 2'd1;
        endcase
        thr = t0 + frame_q;
    end

    // Next-state of the phase counters; new_frame overrides a coincident new_line
    always_comb begin
        xph_d   = xph_q;
        yph_d   = yph_q;
        frame_d = frame_q;
        if (new_line) begin
            xph_d = 1'b0;
        end else if (pixel_en && active_in) begin
            xph_d = ~xph_q;
        end
        if (new_frame) begin
            yph_d = 1'b0;
        end else if (new_line) begin
            yph_d = ~yph_q;
        end
        if (TEMPORAL && new_frame) begin
            frame_d = frame_q + 2'd1;
        end
    end

    // Stage 1 captures every cycle; no stalls
    always_comb begin
        rgb_s1_d       = rgb_in;
        active_s1_d    = active_in;
        hsync_s1_d     = hsync_in;
        vsync_s1_d     = vsync_in;
        thr_s1_d       = thr;
        dither_en_s1_d = dither_en;
    end

    // Stage 2 quantises each channel and forces black outside the visible area
    always_comb begin
        rgb_out_d = '0;
        if (active_s1_q) begin
            for (int c = 0; c < 3; c++) begin
                rgb_out_d[c*OUT_BITS +: OUT_BITS] =
                    quantise(rgb_s1_q[c*IN_BITS +: IN_BITS], thr_s1_q, dither_en_s1_q);
            end
        end
        hsync_out_d  = hsync_s1_q;
        vsync_out_d  = vsync_s1_q;
        active_out_d = active_s1_q;
    end

    // All state, cleared together by the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            xph_q          <= 1'b0;
            yph_q          <= 1'b0;
            frame_q        <= 2'd0;
            rgb_s1_q       <= '0;
            active_s1_q    <= 1'b0;
            hsync_s1_q     <= 1'b0;
            vsync_s1_q     <= 1'b0;
            thr_s1_q       <= 2'd0;
            dither_en_s1_q <= 1'b0;
            rgb_out_q      <= '0;
            hsync_out_q    <= 1'b0;
            vsync_out_q    <= 1'b0;
            active_out_q   <= 1'b0;
        end else begin
            xph_q          <= xph_d;
            yph_q          <= yph_d;
            frame_q        <= frame_d;
            rgb_s1_q       <= rgb_s1_d;
            active_s1_q    <= active_s1_d;
            hsync_s1_q     <= hsync_s1_d;
            vsync_s1_q     <= vsync_s1_d;
            thr_s1_q       <= thr_s1_d;
            dither_en_s1_q <= dither_en_s1_d;
            rgb_out_q      <= rgb_out_d;
            hsync_out_q    <= hsync_out_d;
            vsync_out_q    <= vsync_out_d;
            active_out_q   <= active_out_d;
        end
    end

    assign rgb_out    = rgb_out_q;
    assign hsync_out  = hsync_out_q;
    assign vsync_out  = vsync_out_q;
    assign active_out = active_out_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// tb/tb_vga_dither_out.sv - self-checking bench for vga_dither_out, static and temporal variants
module tb_vga_dither_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rgb_in;
    logic        active_in, hsync_in, vsync_in, pixel_en, new_line, new_frame, dither_en;
    logic [5:0]  rgb_out_s, rgb_out_t;
    logic        hsync_out_s, vsync_out_s, active_out_s;
    logic        hsync_out_t, vsync_out_t, active_out_t;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [5:0] rgb_s;
        logic [5:0] rgb_t;
        logic       hs;
        logic       vs;
        logic       act;
    } exp_t;

    exp_t e_cur, e_d1;
    int   m_x, m_y, m_f;
    logic [5:0] cap_s [0:11];
    logic [5:0] cap_t [0:11];
    logic [5:0] ex_s  [0:11];
    logic [5:0] ex_t  [0:11];

    vga_dither_out #(.IN_BITS(4), .OUT_BITS(2), .TEMPORAL(1'b0)) dut_s (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .active_in(active_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_en(pixel_en),
        .new_line(new_line), .new_frame(new_frame), .dither_en(dither_en),
        .rgb_out(rgb_out_s), .hsync_out(hsync_out_s), .vsync_out(vsync_out_s),
        .active_out(active_out_s)
    );

    vga_dither_out #(.IN_BITS(4), .OUT_BITS(2), .TEMPORAL(1'b1)) dut_t (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .active_in(active_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_en(pixel_en),
        .new_line(new_line), .new_frame(new_frame), .dither_en(dither_en),
        .rgb_out(rgb_out_t), .hsync_out(hsync_out_t), .vsync_out(vsync_out_t),
        .active_out(active_out_t)
    );

    always #5 clk = ~clk;

    function automatic int bayer(input int y, input int x);
        if (y == 0) return (x == 0) ? 0 : 2;
        return (x == 0) ? 3 : 1;
    endfunction

    function automatic logic [1:0] quant(input int c, input int t, input bit de, input bit act);
        int v;
        if (!act) return 2'd0;
        v = c / 4;
        if (de && ((c % 4) > t)) v = v + 1;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    // Drive one clock of stimulus, advance the reference model, return at the next negedge.
    // Afterwards the DUT outputs correspond to e_d1 (the previous call's inputs).
    task automatic step(input logic [11:0] rgb, input bit act, input bit hs, input bit vs,
                        input bit pe, input bit nl, input bit nf, input bit de, input bit rst);
        int ts, tt, ch;
        rgb_in = rgb; active_in = act; hsync_in = hs; vsync_in = vs;
        pixel_en = pe; new_line = nl; new_frame = nf; dither_en = de; reset = rst;
        e_d1 = e_cur;
        if (rst) begin
            e_cur = '0;
            e_d1  = '0;
            m_x = 0; m_y = 0; m_f = 0;
        end else begin
            ts = bayer(m_y, m_x);
            tt = (ts + m_f) % 4;
            for (int c = 0; c < 3; c++) begin
                ch = int'((rgb >> (c * 4)) & 12'hF);
                e_cur.rgb_s[c*2 +: 2] = quant(ch, ts, de, act);
                e_cur.rgb_t[c*2 +: 2] = quant(ch, tt, de, act);
            end
            e_cur.hs = hs; e_cur.vs = vs; e_cur.act = act;
            if (nl) m_x = 0; else if (pe && act) m_x = 1 - m_x;
            if (nf) m_y = 0; else if (nl) m_y = 1 - m_y;
            if (nf) m_f = (m_f + 1) % 4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Strobe a line (optionally a frame) start, then nlines lines of 4 two-clock pixels of
    // constant value v; records the first-cycle output of every pixel and the model's value.
    task automatic run_frame(input logic [3:0] v, input bit de, input bit act,
                             input int nlines, input bit do_nf);
        int k;
        for (int l = 0; l < nlines; l++) begin
            step(12'h000, 0, 0, 0, 0, 1, (l == 0) && do_nf, de, 0);
            for (int p = 0; p < 4; p++) begin
                step({v, v, v}, act, 0, 0, 0, 0, 0, de, 0);
                step({v, v, v}, act, 0, 0, 1, 0, 0, de, 0);
                k = l * 4 + p;
                cap_s[k] = rgb_out_s; cap_t[k] = rgb_out_t;
                ex_s[k]  = e_d1.rgb_s; ex_t[k]  = e_d1.rgb_t;
            end
        end
    endtask

    task automatic test_reset();
        step(12'hFFF, 1, 1, 0, 0, 0, 0, 1, 1);
        n_chk++;
        if (rgb_out_s !== 6'd0 || rgb_out_t !== 6'd0) begin
            n_fail++; $display("FAIL reset_rgb: got %h/%h expected 00", rgb_out_s, rgb_out_t);
        end
        n_chk++;
        if (hsync_out_s !== 1'b0 || hsync_out_t !== 1'b0) begin
            n_fail++; $display("FAIL reset_hsync: got %b/%b expected 0", hsync_out_s, hsync_out_t);
        end
        n_chk++;
        if (active_out_s !== 1'b0 || active_out_t !== 1'b0) begin
            n_fail++; $display("FAIL reset_active: got %b/%b expected 0", active_out_s, active_out_t);
        end
        step(12'hFFF, 1, 1, 0, 0, 0, 0, 1, 0);
        n_chk++;
        if (hsync_out_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_hsync_early: got %b expected 0", hsync_out_s);
        end
        step(12'hFFF, 1, 1, 0, 0, 0, 0, 1, 0);
        n_chk++;
        if (hsync_out_s !== 1'b1 || hsync_out_t !== 1'b1) begin
            n_fail++; $display("FAIL reset_hsync_rise: got %b/%b expected 1", hsync_out_s, hsync_out_t);
        end
        n_chk++;
        if (rgb_out_s !== 6'h3F || active_out_s !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_pixel: got %h/%b expected 3f/1", rgb_out_s, active_out_s);
        end
    endtask

    task automatic test_static_pattern();
        logic [1:0] want;
        run_frame(4'h6, 1, 1, 3, 1);
        for (int k = 0; k < 12; k++) begin
            want = (((k / 4) % 2) == (k % 2)) ? 2'd2 : 2'd1;
            n_chk++;
            if (cap_s[k] !== {3{want}} || cap_s[k] !== ex_s[k]) begin
                n_fail++;
                $display("FAIL static_px%0d: got %h expected %h", k, cap_s[k], {3{want}});
            end
            n_chk++;
            if (cap_t[k] !== ex_t[k]) begin
                n_fail++; $display("FAIL static_temporal_px%0d: got %h expected %h", k, cap_t[k], ex_t[k]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [3:0] vals [0:2];
        logic [1:0] want;
        vals[0] = 4'hF; vals[1] = 4'h0; vals[2] = 4'hB;
        for (int i = 0; i < 3; i++) begin
            run_frame(vals[i], 1, 1, 2, 1);
            for (int k = 0; k < 8; k++) begin
                if (i == 0)      want = 2'd3;
                else if (i == 1) want = 2'd0;
                else             want = ((k / 4) == 1 && (k % 2) == 0) ? 2'd2 : 2'd3;
                n_chk++;
                if (cap_s[k] !== {3{want}} || cap_s[k] !== ex_s[k]) begin
                    n_fail++;
                    $display("FAIL extreme_%h_px%0d: got %h expected %h", vals[i], k, cap_s[k], {3{want}});
                end
            end
        end
    endtask

    task automatic test_truncation_blanking();
        run_frame(4'h7, 0, 1, 2, 1);
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (cap_s[k] !== 6'b010101 || cap_t[k] !== 6'b010101) begin
                n_fail++; $display("FAIL trunc_px%0d: got %h/%h expected 15", k, cap_s[k], cap_t[k]);
            end
        end
        run_frame(4'hF, 1, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (cap_s[k] !== 6'd0 || cap_t[k] !== 6'd0) begin
                n_fail++; $display("FAIL blank_px%0d: got %h/%h expected 00", k, cap_s[k], cap_t[k]);
            end
        end
    endtask

    task automatic test_temporal();
        logic [1:0] want [0:4];
        want[0] = 2'd2; want[1] = 2'd2; want[2] = 2'd1; want[3] = 2'd1; want[4] = 2'd2;
        step(12'h000, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) run_frame(4'h6, 1, 1, 1, 1);
        for (int f = 0; f < 5; f++) begin
            run_frame(4'h6, 1, 1, 1, 1);
            n_chk++;
            if (cap_t[0] !== {3{want[f]}} || cap_t[0] !== ex_t[0]) begin
                n_fail++; $display("FAIL temporal_f%0d: got %h expected %h", f, cap_t[0], {3{want[f]}});
            end
            n_chk++;
            if (cap_s[0] !== 6'b101010) begin
                n_fail++; $display("FAIL temporal_static_f%0d: got %h expected 2a", f, cap_s[0]);
            end
        end
    endtask

    task automatic test_simultaneous_strobes();
        run_frame(4'h6, 1, 1, 2, 1);
        n_chk++;
        if (cap_s[4] !== 6'b010101) begin
            n_fail++; $display("FAIL simul_pre_yph1: got %h expected 15", cap_s[4]);
        end
        run_frame(4'h6, 1, 1, 1, 1);
        n_chk++;
        if (cap_s[0] !== 6'b101010 || cap_s[1] !== 6'b010101) begin
            n_fail++; $display("FAIL simul_yph0: got %h,%h expected 2a,15", cap_s[0], cap_s[1]);
        end
    endtask

    task automatic test_random();
        bit act, nl, nf;
        act = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 2 == 0) act = ($urandom_range(0, 3) != 0);
            nl = ($urandom_range(0, 15) == 0);
            nf = ($urandom_range(0, 47) == 0);
            step(12'($urandom), act, 1'($urandom), 1'($urandom), (i % 2) == 1, nl, nf,
                 ($urandom_range(0, 4) != 0), 0);
            n_chk++;
            if ({rgb_out_s, rgb_out_t, hsync_out_s, vsync_out_s, active_out_s,
                 hsync_out_t, vsync_out_t, active_out_t} !== {e_d1, e_d1.hs, e_d1.vs, e_d1.act}) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h,%h,%b%b%b,%b%b%b expected %h,%h,%b%b%b", i,
                         rgb_out_s, rgb_out_t, hsync_out_s, vsync_out_s, active_out_s,
                         hsync_out_t, vsync_out_t, active_out_t,
                         e_d1.rgb_s, e_d1.rgb_t, e_d1.hs, e_d1.vs, e_d1.act);
            end
        end
    endtask

    initial begin
        reset = 1'b1; rgb_in = '0; active_in = 0; hsync_in = 0; vsync_in = 0;
        pixel_en = 0; new_line = 0; new_frame = 0; dither_en = 0;
        e_cur = '0; e_d1 = '0; m_x = 0; m_y = 0; m_f = 0;
        @(negedge clk);
        test_reset();
        test_static_pattern();
        test_extremes();
        test_truncation_blanking();
        test_temporal();
        test_simultaneous_strobes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
